// File: rtl/maroc_sc_sequencer.sv
// -----------------------------------------------------------------------------
// maroc_sc_sequencer
//
// Control stage sitting directly in front of the MAROC slow-control
// transmitter. A start request runs one complete configuration cycle:
//   1. hold the MAROC SC register in reset (sc_rstn low) for RST_CYCLES clocks;
//   2. drop load for exactly FRAME_BITS clocks so the transmitter shifts the
//      frame out LSB first;
//   3. enable the CK_SC clock gate one clock later, for FRAME_BITS clocks, so
//      it lines up with the transmitter's registered D_SC output;
//   4. signal completion with a one-clock done pulse.
// A running cycle can be cancelled with abort, which returns to idle and
// pulses aborted instead of done.
//
// Ports
//   CK_in     system clock (shared with the transmitter)
//   rst       synchronous, active-high reset
//   start     request a configuration cycle (only honoured while idle)
//   abort     cancel the running cycle (honoured in RESET/SHIFT/TAIL)
//   load      transmitter state input: 1 = parallel reload, 0 = shift
//   sc_rstn   active-low reset to the MAROC SC register
//   ck_sc_en  CK_SC clock-gate enable, high exactly while D_SC is valid
//   busy      high while a cycle is in progress
//   done      one-clock pulse when a full frame has been sent
//   aborted   one-clock pulse after an abort
//   bit_cnt   index of the frame bit being shifted, 0 outside SHIFT
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module maroc_sc_sequencer #(
  parameter int unsigned FRAME_BITS = 829,
  parameter int unsigned RST_CYCLES = 50,
  parameter int unsigned CNT_W      = 10
) (
  input  logic             CK_in,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             load,
  output logic             sc_rstn,
  output logic             ck_sc_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RESET = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_TAIL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Terminal counts: counters compare against these and clear, never wrap.
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

  logic [2:0]       state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic             load_q,     load_d;
  logic             sc_rstn_q,  sc_rstn_d;
  logic             ck_sc_en_q, ck_sc_en_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             aborted_q,  aborted_d;

  // Next-state and next-output logic. Every output flop is loaded with the
  // value it must show in the state being entered, so all outputs change on
  // the same edge as the state register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    bit_cnt_d  = '0;
    load_d     = 1'b1;
    sc_rstn_d  = 1'b1;
    ck_sc_en_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort is not looked at here, so start always wins.
        if (start) begin
          state_d   = ST_RESET;
          sc_rstn_d = 1'b0;
          busy_d    = 1'b1;
        end
      end

      ST_RESET: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (cnt_q == RST_LAST) begin
          state_d = ST_SHIFT;
          load_d  = 1'b0;
          busy_d  = 1'b1;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          sc_rstn_d = 1'b0;
          busy_d    = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else begin
          // Gate enable is SHIFT delayed by one clock: D_SC is registered in
          // the transmitter, so the bit shifted this cycle is valid next cycle.
          ck_sc_en_d = 1'b1;
          busy_d     = 1'b1;
          if (bit_cnt_q == FRAME_LAST) begin
            state_d = ST_TAIL;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            load_d    = 1'b0;
          end
        end
      end

      ST_TAIL: begin
        // One extra clock while the last D_SC bit is clocked out.
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK_in) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      load_q     <= 1'b1;
      sc_rstn_q  <= 1'b1;
      ck_sc_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      load_q     <= load_d;
      sc_rstn_q  <= sc_rstn_d;
      ck_sc_en_q <= ck_sc_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign load     = load_q;
  assign sc_rstn  = sc_rstn_q;
  assign ck_sc_en = ck_sc_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_maroc_sc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_maroc_sc_sequencer
//
// Self-checking bench. The reference model describes a configuration cycle
// purely by its position (1 .. R+F+2 clocks since the accepted start edge)
// and derives every expected output from that position with plain range
// arithmetic. A tiny transmitter model (reload on load, else shift LSB out
// into a registered D_SC) checks that ck_sc_en frames exactly the frame bits.
// -----------------------------------------------------------------------------
module tb_maroc_sc_sequencer;

  localparam int R = 50;
  localparam int F = 829;
  localparam int W = 10;
  localparam int T = R + F + 2;   // position of the done cycle

  logic         CK_in = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic         load, sc_rstn, ck_sc_en, busy, done, aborted;
  logic [W-1:0] bit_cnt;

  maroc_sc_sequencer #(
    .FRAME_BITS(F),
    .RST_CYCLES(R),
    .CNT_W     (W)
  ) dut (
    .CK_in   (CK_in),
    .rst     (rst_i),
    .start   (start_i),
    .abort   (abort_i),
    .load    (load),
    .sc_rstn (sc_rstn),
    .ck_sc_en(ck_sc_en),
    .busy    (busy),
    .done    (done),
    .aborted (aborted),
    .bit_cnt (bit_cnt)
  );

  always #5 CK_in = ~CK_in;

  // Transmitter model: reload while load=1, otherwise shift out LSB first
  // into a registered D_SC.
  logic [F-1:0] frame;
  logic [F-1:0] sr;
  logic         d_sc;
  always @(posedge CK_in) begin
    if (load) sr <= frame;
    else begin
      d_sc <= sr[0];
      sr   <= sr >> 1;
    end
  end

  // Reference model state: pos = 0 idle, else clocks since the start edge.
  int pos = 0;
  bit ab  = 1'b0;
  int cyc = 0;
  int start_cyc = 0;

  int checks = 0;
  int errors = 0;

  // Measurements of DUT behaviour (totals; tests take differences).
  int tot_rstn_lo = 0, tot_load_lo = 0, tot_ck = 0, tot_busy = 0;
  int tot_done = 0, tot_ab = 0;
  int last_done = 0, prev_done = 0;
  int load_fall = 0, ck_rise = 0;
  bit prev_load = 1'b1, prev_ck = 1'b0;
  bit cap_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit a);
    if (r) begin
      pos = 0; ab = 1'b0;
    end else if (pos == 0) begin
      ab = 1'b0;
      if (s) begin pos = 1; start_cyc = cyc; end
    end else if (a && pos <= R + F + 1) begin
      pos = 0; ab = 1'b1;
    end else if (pos == T) begin
      pos = 0; ab = 1'b0;
    end else begin
      pos++; ab = 1'b0;
    end
  endtask

  task automatic compare();
    logic         e_load, e_rstn, e_ck, e_busy, e_done;
    logic [W-1:0] e_bit;
    e_busy = (pos >= 1 && pos <= R + F + 1);
    e_rstn = !(pos >= 1 && pos <= R);
    e_load = !(pos >= R + 1 && pos <= R + F);
    e_bit  = (pos >= R + 1 && pos <= R + F) ? W'(pos - R - 1) : '0;
    e_ck   = (pos >= R + 2 && pos <= R + F + 1);
    e_done = (pos == T);
    checks++;
    if (load !== e_load || sc_rstn !== e_rstn || ck_sc_en !== e_ck ||
        busy !== e_busy || done !== e_done || aborted !== ab ||
        bit_cnt !== e_bit) begin
      errors++;
      $display("FAIL cycle %0d pos %0d: got load=%b rstn=%b ck=%b busy=%b done=%b ab=%b bit=%0d expected load=%b rstn=%b ck=%b busy=%b done=%b ab=%b bit=%0d",
               cyc, pos, load, sc_rstn, ck_sc_en, busy, done, aborted, bit_cnt,
               e_load, e_rstn, e_ck, e_busy, e_done, ab, e_bit);
    end
  endtask

  // One clock: drive inputs, step the model on the edge, check on the
  // falling edge.
  task automatic tick(input bit r, input bit s, input bit a);
    rst_i = r; start_i = s; abort_i = a;
    @(posedge CK_in);
    cyc++;
    model_step(r, s, a);
    @(negedge CK_in);
    compare();
    if (sc_rstn === 1'b0) tot_rstn_lo++;
    if (load === 1'b0) tot_load_lo++;
    if (busy === 1'b1) tot_busy++;
    if (ck_sc_en === 1'b1) begin tot_ck++; cap_q.push_back(d_sc); end
    if (done === 1'b1) begin tot_done++; prev_done = last_done; last_done = cyc; end
    if (aborted === 1'b1) tot_ab++;
    if (prev_load && load === 1'b0) load_fall = cyc;
    if (!prev_ck && ck_sc_en === 1'b1) ck_rise = cyc;
    prev_load = (load !== 1'b0);
    prev_ck   = (ck_sc_en === 1'b1);
  endtask

  task automatic advance_to(input int target);
    for (int n = 0; n < 3000 && pos != target; n++) tick(0, 0, 0);
    check("reach_position", pos, target);
  endtask

  task automatic run_to_idle();
    for (int n = 0; n < 3000 && pos != 0; n++) tick(0, 0, 0);
    check("return_to_idle", pos, 0);
    for (int n = 0; n < 3; n++) tick(0, 0, 0);
  endtask

  int b_rstn, b_load, b_ck, b_busy, b_done, b_ab, b_cap, bad;

  task automatic snap();
    b_rstn = tot_rstn_lo; b_load = tot_load_lo; b_ck = tot_ck;
    b_busy = tot_busy; b_done = tot_done; b_ab = tot_ab; b_cap = cap_q.size();
  endtask

  initial begin
    for (int i = 0; i < F; i++) frame[i] = 1'($urandom & 1);

    // 1: reset, then 100 idle clocks
    for (int n = 0; n < 3; n++) tick(1, 0, 0);
    snap();
    for (int n = 0; n < 100; n++) tick(0, 0, 0);
    check("idle_busy_cycles", tot_busy - b_busy, 0);
    check("idle_load_low_cycles", tot_load_lo - b_load, 0);
    check("idle_rstn_low_cycles", tot_rstn_lo - b_rstn, 0);

    // 2: single start pulse
    snap();
    tick(0, 1, 0);
    run_to_idle();
    check("rstn_low_cycles", tot_rstn_lo - b_rstn, 50);
    check("load_low_cycles", tot_load_lo - b_load, 829);
    check("ck_en_cycles", tot_ck - b_ck, 829);
    check("ck_rise_after_load_fall", ck_rise - load_fall, 1);
    check("done_pulses", tot_done - b_done, 1);
    // done occupies the 881st clock counting the start edge as clock 1
    check("done_latency", last_done - start_cyc + 1, 881);
    check("captured_bits", cap_q.size() - b_cap, F);
    bad = 0;
    for (int i = 0; i < F; i++)
      if (b_cap + i < cap_q.size() && cap_q[b_cap + i] !== frame[i]) bad++;
    check("dsc_bit_errors", bad, 0);

    // 3: start at bit_cnt=400 is ignored
    snap();
    tick(0, 1, 0);
    advance_to(R + 1 + 400);
    check("bit_cnt_at_400", int'(bit_cnt), 400);
    tick(0, 1, 0);
    run_to_idle();
    check("busy_start_load_low", tot_load_lo - b_load, 829);
    check("busy_start_done_latency", last_done - start_cyc + 1, 881);
    check("busy_start_done_pulses", tot_done - b_done, 1);

    // 4: abort at bit_cnt=300, then a full cycle
    snap();
    tick(0, 1, 0);
    advance_to(R + 1 + 300);
    tick(0, 0, 1);
    check("abort_ck_en_now", int'(ck_sc_en), 0);
    check("abort_pulse_now", int'(aborted), 1);
    for (int n = 0; n < 5; n++) tick(0, 0, 0);
    check("abort_pulses", tot_ab - b_ab, 1);
    check("abort_done_pulses", tot_done - b_done, 0);
    check("abort_ck_cycles", tot_ck - b_ck, 300);
    snap();
    tick(0, 1, 0);
    run_to_idle();
    check("after_abort_latency", last_done - start_cyc + 1, 881);
    check("after_abort_done_pulses", tot_done - b_done, 1);

    // abort together with start in idle: start wins
    tick(0, 1, 1);
    check("start_beats_abort_busy", int'(busy), 1);
    run_to_idle();

    // 5: rst at bit_cnt=500
    snap();
    tick(0, 1, 0);
    advance_to(R + 1 + 500);
    tick(1, 0, 0);
    check("rst_ck_en_now", int'(ck_sc_en), 0);
    check("rst_load_now", int'(load), 1);
    for (int n = 0; n < 5; n++) tick(0, 0, 0);
    check("rst_done_pulses", tot_done - b_done, 0);
    check("rst_abort_pulses", tot_ab - b_ab, 0);

    // 6: start held high -> back-to-back cycles
    snap();
    for (int n = 0; n < 3 * 882; n++) tick(0, 1, 0);
    for (int n = 0; n < 5; n++) tick(0, 0, 0);
    check("b2b_done_pulses", tot_done - b_done, 3);
    check("b2b_done_period", last_done - prev_done, 882);
    check("b2b_rstn_low_cycles", tot_rstn_lo - b_rstn, 150);

    // 7: randomized traffic against the model
    for (int n = 0; n < 6000; n++)
      tick(($urandom % 2000) == 0, ($urandom % 40) == 0, ($urandom % 300) == 0);
    run_to_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
